hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
- Time-multiplexed driver for a bank of NUM_DIGITS common-anode/cathode 7-segment hex digits sharing one segment bus.
- Takes a packed hex value with per-digit decimal-point and blank masks, and scans one digit per slot.
- Adds a tear-free shadow load, leading-zero suppression and inter-digit ghost blanking.
- Sits between the CPU debug/status registers and the board LED pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..16)
SCAN_DIV, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 2, cycles at the start of each slot with all digits off (0..SCAN_DIV-1)
SEG_ACTIVE_LOW, 0, 1 = SEGLED and DP are driven active-low
DIG_ACTIVE_LOW, 1, 1 = DIGSEL is driven active-low
LZ_SUPPRESS, 1, 1 = blank leading zero digits

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
VALUE  in  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 least significant
DP_IN  in  NUM_DIGITS  decimal point enable per digit
BLANK_IN  in  NUM_DIGITS  force digit i dark
LOAD  in  1  capture VALUE/DP_IN/BLANK_IN into pending register
SEGLED  out  7  segments, bit0=a .. bit6=g
DP  out  1  decimal point segment
DIGSEL  out  NUM_DIGITS  one-hot digit enable
FRAME  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clocking/reset: single clock CLK; RESET is synchronous and active-high, sampled on the rising edge of CLK.
- Reset: prescaler=0, digit index=0, pending and active registers=0, FRAME=0.
  - SEGLED/DP are driven at their inactive level: 0, or all-1 if SEG_ACTIVE_LOW.
  - DIGSEL is all inactive.
  - RESET mid-scan aborts immediately; no partial-digit output follows.
- Prescaler cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, digit index idx advances 0..NUM_DIGITS-1 and wraps to 0.
- Frame boundary: the cycle in which cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1.
  - The pending register is copied to active; FRAME=1 in the following cycle, aligned with the registered outputs.
- LOAD writes pending in any cycle; the value becomes visible only from the next frame (no tearing).
  - If LOAD coincides with the boundary cycle, the newly loaded data goes straight to active (the bypass wins).
  - Repeated LOADs within a frame: the last one wins.
- Glyphs (bit6..bit0 = g..a), active-high form:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111.
  - 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
  - Inverted when SEG_ACTIVE_LOW=1.
- Leading zeros (LZ_SUPPRESS=1): digit i is dark if nibbles NUM_DIGITS-1..i of active are all zero and i>0.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its DP if its active DP bit is set.
- Dark digit (blank mask, suppression, or ghost window): SEGLED is inactive, and DIGSEL still selects idx.
  - Exception — ghost window: while cnt<BLANK_CYCLES, DIGSEL is all inactive and SEGLED/DP are inactive.
- Output timing: all outputs are registered, one cycle latency from (cnt, idx, active).
  - DIGSEL is exactly one-hot (or all-off in the ghost window); never two digits on.
- After RESET deasserts, the first output cycle shows the digit 0 slot; a full frame is NUM_DIGITS*SCAN_DIV cycles.
- Width rules: cnt width clog2(SCAN_DIV); idx width clog2(NUM_DIGITS), minimum 1. No overflow beyond the wrap compare.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry glyph constant array;
  - SEG_OFF/SEG_ON level constants;
  - the localparam helper for counter widths.
- One sub-module, seg7_glyph: combinational nibble-to-7-bit lookup using the package table, with polarity applied in the top level.
- The top level holds the prescaler, digit index, pending/active registers, suppression logic and output registers.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1, LZ_SUPPRESS=1):
- Reset held 3 cycles then released, no LOAD -> SEGLED=0000000 and DIGSEL=1111 during reset.
  - Digit 0 slot then shows 0111111 ("0") on cycles 2-4 with DIGSEL=1110.
  - Digits 1-3 are dark (suppressed); FRAME pulses every 16 cycles.
- LOAD VALUE=16'h00A5 mid-frame -> no change until the next FRAME.
  - Then digit 0=1101101, digit 1=1110111, digits 2-3 dark.
- LOAD VALUE=16'h8000, DP_IN=4'b0100 -> digits 3..0 show 1111111, 0111111+DP, 0111111, 0111111 (no suppression below a nonzero MSB).
- BLANK_IN=4'b0001 with VALUE=16'h1234 -> digit 0 slot has DIGSEL=1110 and SEGLED=0000000; the other three digits show 1/2/3.
- LOAD asserted exactly on the boundary cycle with 16'hFFFF -> the very next frame shows F on all digits; a LOAD of 16'h0001 one cycle later takes effect one frame later.
- RESET asserted in the digit 2 slot -> the next cycle gives all-off outputs and idx=0.
  - After release the scan restarts at digit 0 and the active value is 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks: glyph table,
// segment level constants and a counter width helper.
package seg7_pkg;

    // Active-high segment levels; polarity inversion is applied at the pins.
    localparam logic SEG_ON  = 1'b1;
    localparam logic SEG_OFF = 1'b0;

    // Hex glyphs, bit6..bit0 = g..a, active-high form.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Width of a counter that spans 0..n-1, never less than one bit.
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-segment lookup (active-high glyphs).
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; polarity is handled by the caller.
    assign seg = GLYPH[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display scanner with tear-free shadow load,
// leading-zero suppression and inter-digit ghost blanking.
module hex_display_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int LZ_SUPPRESS    = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   BLANK_IN,
    input  logic                    LOAD,
    output logic [6:0]              SEGLED,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   DIGSEL,
    output logic                    FRAME
);

    localparam int   CNT_W   = ctr_width(SCAN_DIV);
    localparam int   IDX_W   = ctr_width(NUM_DIGITS);
    localparam int   VAL_W   = 4 * NUM_DIGITS;
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_POL = (DIG_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      pend_val, act_val;
    logic [NUM_DIGITS-1:0] pend_dp, act_dp;
    logic [NUM_DIGITS-1:0] pend_blank, act_blank;

    logic cnt_wrap, idx_wrap, boundary, ghost;

    assign cnt_wrap = (cnt == CNT_W'(SCAN_DIV - 1));
    assign idx_wrap = (idx == IDX_W'(NUM_DIGITS - 1));
    assign boundary = cnt_wrap && idx_wrap;

    // Ghost window: the first BLANK_CYCLES cycles of every slot are dark.
    generate
        if (BLANK_CYCLES > 0) begin : g_ghost
            assign ghost = (cnt < CNT_W'(BLANK_CYCLES));
        end else begin : g_no_ghost
            assign ghost = 1'b0;
        end
    endgenerate

    // Prescaler and digit index: cnt wraps every SCAN_DIV cycles, idx steps on the wrap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_wrap) begin
            cnt <= '0;
            idx <= idx_wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow load: LOAD fills pending; the frame boundary copies it to active,
    // taking the freshly loaded inputs directly if LOAD lands on that cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else begin
            if (LOAD) begin
                pend_val   <= VALUE;
                pend_dp    <= DP_IN;
                pend_blank <= BLANK_IN;
            end
            if (boundary) begin
                act_val   <= LOAD ? VALUE    : pend_val;
                act_dp    <= LOAD ? DP_IN    : pend_dp;
                act_blank <= LOAD ? BLANK_IN : pend_blank;
            end
        end
    end

    logic [NUM_DIGITS-1:0] lz;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank, cur_lz;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic [6:0]            glyph;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [NUM_DIGITS-1:0] dig_n;

    // Leading-zero mask and the selected digit's attributes for the current slot.
    always_comb begin
        zero_run  = 1'b1;
        lz        = '0;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        dig_sel   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_val[4*i +: 4] == 4'h0);
            lz[i]    = (LZ_SUPPRESS != 0) && (i > 0) && zero_run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib    = act_val[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_blank  = act_blank[i];
                cur_lz     = lz[i];
                dig_sel[i] = 1'b1;
            end
        end
    end

    seg7_glyph u_glyph (
        .nibble (cur_nib),
        .seg    (glyph)
    );

    // Active-high next outputs: blanked digits kill segments and DP,
    // suppressed digits keep their DP, the ghost window kills everything.
    always_comb begin
        seg_n = {7{SEG_OFF}};
        dp_n  = SEG_OFF;
        dig_n = '0;
        if (!ghost) begin
            dig_n = dig_sel;
            if (!cur_blank) begin
                dp_n = cur_dp ? SEG_ON : SEG_OFF;
                if (!cur_lz) begin
                    seg_n = glyph;
                end
            end
        end
    end

    // Registered pin drivers with polarity applied; reset forces everything off.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SEGLED <= {7{SEG_POL}};
            DP     <= SEG_POL;
            DIGSEL <= {NUM_DIGITS{DIG_POL}};
            FRAME  <= 1'b0;
        end else begin
            SEGLED <= seg_n ^ {7{SEG_POL}};
            DP     <= dp_n ^ SEG_POL;
            DIGSEL <= dig_n ^ {NUM_DIGITS{DIG_POL}};
            FRAME  <= boundary;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner (4 digits, 4-cycle slots, 1 ghost cycle).
module tb_hex_display_scanner;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] VALUE;
    logic [3:0]  DP_IN;
    logic [3:0]  BLANK_IN;
    logic        LOAD;
    logic [6:0]  SEGLED;
    logic        DP;
    logic [3:0]  DIGSEL;
    logic        FRAME;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] cap_seg [16];
    logic       cap_dp  [16];
    logic [3:0] cap_dig [16];

    hex_display_scanner #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .BLANK_CYCLES   (1),
        .SEG_ACTIVE_LOW (0),
        .DIG_ACTIVE_LOW (1),
        .LZ_SUPPRESS    (1)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .VALUE    (VALUE),
        .DP_IN    (DP_IN),
        .BLANK_IN (BLANK_IN),
        .LOAD     (LOAD),
        .SEGLED   (SEGLED),
        .DP       (DP),
        .DIGSEL   (DIGSEL),
        .FRAME    (FRAME)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Advance to the next negedge on which FRAME is high (bounded).
    task automatic wait_frame();
        bit seen = 1'b0;
        int k = 0;
        while (!seen && k < 40) begin
            @(negedge CLK);
            seen = FRAME;
            k++;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_frame: FRAME not seen within 40 cycles");
        end
    endtask

    // Record the 16 output cycles of one frame; LOAD is dropped after the first edge.
    task automatic capture16();
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            LOAD       = 1'b0;
            cap_seg[c] = SEGLED;
            cap_dp[c]  = DP;
            cap_dig[c] = DIGSEL;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        RESET = 1'b1; LOAD = 1'b0; VALUE = '0; DP_IN = '0; BLANK_IN = '0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({SEGLED, DP, DIGSEL, FRAME} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got seg=%b dp=%b dig=%b frame=%b want 0000000/0/1111/0",
                     SEGLED, DP, DIGSEL, FRAME);
        end
        RESET = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            int d, k;
            @(negedge CLK);
            d = (c - 1) / 4;
            k = (c - 1) % 4;
            exp_dig = (k == 0) ? 4'hF : ~(4'b0001 << d);
            exp_seg = (k != 0 && d == 0) ? 7'h3F : 7'h00;
            n_cmp++;
            if ({SEGLED, DP, DIGSEL, FRAME} !== {exp_seg, 1'b0, exp_dig, (c == 16)}) begin
                n_err++;
                $display("FAIL reset_first_frame c=%0d: got seg=%b dp=%b dig=%b frame=%b want %b/0/%b/%b",
                         c, SEGLED, DP, DIGSEL, FRAME, exp_seg, exp_dig, (c == 16));
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [6:0] es [4];
        es = '{7'h6D, 7'h77, 7'h00, 7'h00};
        wait_frame();
        @(negedge CLK);
        LOAD = 1'b1; VALUE = 16'h00A5; DP_IN = 4'h0; BLANK_IN = 4'h0;
        @(negedge CLK);
        LOAD = 1'b0;
        for (int c = 2; c <= 15; c++) begin
            @(negedge CLK);
            if (c == 2) begin
                n_cmp++;
                if ({SEGLED, DIGSEL} !== {7'h3F, 4'b1110}) begin
                    n_err++;
                    $display("FAIL midframe_old_d0: got seg=%b dig=%b want 0111111/1110", SEGLED, DIGSEL);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if ({SEGLED, DIGSEL} !== {7'h00, 4'b1101}) begin
                    n_err++;
                    $display("FAIL midframe_old_d1: got seg=%b dig=%b want 0000000/1101", SEGLED, DIGSEL);
                end
            end
        end
        n_cmp++;
        if (FRAME !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_frame_pulse: got %b want 1", FRAME);
        end
        capture16();
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if ({cap_seg[4*d+2], cap_dp[4*d+2], cap_dig[4*d+2]} !== {es[d], 1'b0, ~(4'b0001 << d)}) begin
                n_err++;
                $display("FAIL a5_digit%0d: got seg=%b dp=%b dig=%b want %b/0/%b",
                         d, cap_seg[4*d+2], cap_dp[4*d+2], cap_dig[4*d+2], es[d], ~(4'b0001 << d));
            end
            n_cmp++;
            if ({cap_seg[4*d], cap_dp[4*d], cap_dig[4*d]} !== {7'h00, 1'b0, 4'hF}) begin
                n_err++;
                $display("FAIL a5_ghost%0d: got seg=%b dp=%b dig=%b want 0000000/0/1111",
                         d, cap_seg[4*d], cap_dp[4*d], cap_dig[4*d]);
            end
        end
    endtask

    task automatic test_dp_last_wins();
        logic [6:0] es [4];
        logic       ed [4];
        es = '{7'h3F, 7'h3F, 7'h3F, 7'h7F};
        ed = '{1'b0, 1'b0, 1'b1, 1'b0};
        wait_frame();
        LOAD = 1'b1; VALUE = 16'h1234; DP_IN = 4'b0000; BLANK_IN = 4'h0;
        @(negedge CLK);
        VALUE = 16'h8000; DP_IN = 4'b0100;
        @(negedge CLK);
        LOAD = 1'b0; DP_IN = 4'h0;
        wait_frame();
        capture16();
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if ({cap_seg[4*d+2], cap_dp[4*d+3], cap_dig[4*d+3]} !== {es[d], ed[d], ~(4'b0001 << d)}) begin
                n_err++;
                $display("FAIL dp8000_digit%0d: got seg=%b dp=%b dig=%b want %b/%b/%b",
                         d, cap_seg[4*d+2], cap_dp[4*d+3], cap_dig[4*d+3], es[d], ed[d], ~(4'b0001 << d));
            end
        end
    endtask

    task automatic test_blank_mask();
        logic [6:0] es [4];
        es = '{7'h00, 7'h4F, 7'h5B, 7'h06};
        wait_frame();
        LOAD = 1'b1; VALUE = 16'h1234; DP_IN = 4'h0; BLANK_IN = 4'b0001;
        @(negedge CLK);
        LOAD = 1'b0; BLANK_IN = 4'h0;
        wait_frame();
        capture16();
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if ({cap_seg[4*d+1], cap_dp[4*d+1], cap_dig[4*d+1]} !== {es[d], 1'b0, ~(4'b0001 << d)}) begin
                n_err++;
                $display("FAIL blank_digit%0d: got seg=%b dp=%b dig=%b want %b/0/%b",
                         d, cap_seg[4*d+1], cap_dp[4*d+1], cap_dig[4*d+1], es[d], ~(4'b0001 << d));
            end
        end
    endtask

    task automatic test_boundary_bypass();
        logic [6:0] es [4];
        es = '{7'h06, 7'h00, 7'h00, 7'h00};
        wait_frame();
        repeat (15) @(negedge CLK);
        LOAD = 1'b1; VALUE = 16'hFFFF; DP_IN = 4'h0; BLANK_IN = 4'h0;
        @(negedge CLK);
        n_cmp++;
        if (FRAME !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_on_boundary: got frame=%b want 1", FRAME);
        end
        VALUE = 16'h0001;
        capture16();
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if ({cap_seg[4*d+2], cap_dig[4*d+2]} !== {7'h71, ~(4'b0001 << d)}) begin
                n_err++;
                $display("FAIL bypass_ffff_digit%0d: got seg=%b dig=%b want 1110001/%b",
                         d, cap_seg[4*d+2], cap_dig[4*d+2], ~(4'b0001 << d));
            end
        end
        capture16();
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if ({cap_seg[4*d+3], cap_dig[4*d+3]} !== {es[d], ~(4'b0001 << d)}) begin
                n_err++;
                $display("FAIL after_0001_digit%0d: got seg=%b dig=%b want %b/%b",
                         d, cap_seg[4*d+3], cap_dig[4*d+3], es[d], ~(4'b0001 << d));
            end
        end
    endtask

    task automatic test_reset_midscan();
        wait_frame();
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({SEGLED, DP, DIGSEL, FRAME} !== {7'h00, 1'b0, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL midscan_reset_off: got seg=%b dp=%b dig=%b frame=%b want 0000000/0/1111/0",
                     SEGLED, DP, DIGSEL, FRAME);
        end
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({SEGLED, DIGSEL} !== {7'h00, 4'hF}) begin
            n_err++;
            $display("FAIL midscan_restart_ghost: got seg=%b dig=%b want 0000000/1111", SEGLED, DIGSEL);
        end
        @(negedge CLK);
        n_cmp++;
        if ({SEGLED, DIGSEL} !== {7'h3F, 4'b1110}) begin
            n_err++;
            $display("FAIL midscan_restart_d0: got seg=%b dig=%b want 0111111/1110", SEGLED, DIGSEL);
        end
        wait_frame();
        capture16();
        n_cmp++;
        if ({cap_seg[2], cap_dig[2], cap_seg[6]} !== {7'h3F, 4'b1110, 7'h00}) begin
            n_err++;
            $display("FAIL midscan_pending_cleared: got d0=%b dig=%b d1=%b want 0111111/1110/0000000",
                     cap_seg[2], cap_dig[2], cap_seg[6]);
        end
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_dp_last_wins();
        test_blank_mask();
        test_boundary_bypass();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
